// File: rtl/pixel_pkg.sv
// Shared types and constants for the 24bpp pixel stream unpacker.
package pixel_pkg;

    localparam int BYTES_PER_PIX  = 3;
    localparam int BYTES_PER_WORD = 4;
    localparam int ACC_BYTES      = 8;
    localparam int PRIME_BYTES    = 6;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } unpack_state_t;

endpackage

// File: rtl/byte_accumulator.sv
// Eight-byte holding register: 4-byte words are appended behind the stored
// bytes and 3-byte pixels are removed from the oldest end.
module byte_accumulator
    import pixel_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [23:0] pop_data,
    output logic [3:0]  byte_cnt
);

    localparam int ACC_W = ACC_BYTES * 8;

    // Byte i lives in acc[8*i +: 8]; byte 0 is the oldest.
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [3:0]       cnt_next;
    logic [2:0]       base;
    logic [5:0]       shamt;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        acc_next = acc;
        cnt_next = byte_cnt;
        base     = byte_cnt[2:0];
        if (pop) begin
            acc_next = acc >> (BYTES_PER_PIX * 8);
            cnt_next = byte_cnt - 4'(BYTES_PER_PIX);
            base     = 3'(byte_cnt - 4'(BYTES_PER_PIX));
        end
        shamt = {base, 3'b000};
        if (push) begin
            acc_next = (acc_next & ~(ACC_W'(32'hFFFF_FFFF) << shamt))
                     | (ACC_W'(push_data) << shamt);
            cnt_next = cnt_next + 4'(BYTES_PER_WORD);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the data bytes are reset too, so a mid-frame reset leaves nothing stale behind.
        if (!reset_n) begin
            acc      <= '0;
            byte_cnt <= '0;
        end else begin
            acc      <= acc_next;
            byte_cnt <= cnt_next;
        end
    end

    assign pop_data = acc[BYTES_PER_PIX*8-1:0];

endmodule

// File: rtl/pixel_stream_unpacker.sv
// Unpacks 24bpp words (4 pixels per 3 words) into one RGB pixel per active
// cycle, with fill-colour substitution on underflow and frame-size checking.
module pixel_stream_unpacker
    import pixel_pkg::*;
#(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [23:0] FILL_COLOR = 24'hFF00FF,
    parameter int          UFLOW_W    = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               frame_start,
    input  logic               in_frame,
    output rgb_t               rgb,
    output logic               rgb_valid,
    input  logic               status_clr,
    output logic               underflow,
    output logic [UFLOW_W-1:0] uflow_count,
    output logic               frame_error
);

    localparam int               FRAME_PIX   = H_ACTIVE * V_ACTIVE;
    localparam int               PIX_W       = $clog2(FRAME_PIX + 1);
    localparam logic [PIX_W-1:0] FRAME_PIX_V = PIX_W'(FRAME_PIX);

    unpack_state_t    state;
    unpack_state_t    state_next;
    logic [3:0]       byte_cnt;
    logic [23:0]      pix_data;
    logic             accept;
    logic             run_pix;
    logic             consume;
    logic             uflow_pix;
    logic             frame_bad;
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] pix_cnt_upd;

    // Ready looks only at registers so upstream never sees a valid->ready loop.
    assign s_ready   = (state != IDLE) && (byte_cnt <= 4'(BYTES_PER_WORD));
    assign accept    = s_valid && s_ready;
    assign run_pix   = (state == RUN) && in_frame;
    assign consume   = run_pix && (byte_cnt >= 4'(BYTES_PER_PIX));
    assign uflow_pix = in_frame && ((state == PRIME) || (run_pix && !consume));

    byte_accumulator u_acc (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (s_data),
        .pop       (consume),
        .pop_data  (pix_data),
        .byte_cnt  (byte_cnt)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = PRIME;
            PRIME:   if ((byte_cnt >= 4'(PRIME_BYTES)) && !frame_start) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // The pixel of this cycle is counted before the frame-size check.
    always_comb begin
        pix_cnt_upd = pix_cnt;
        if (run_pix && (pix_cnt != '1)) pix_cnt_upd = pix_cnt + 1'b1;
        frame_bad = frame_start && (state == RUN) && (pix_cnt_upd != FRAME_PIX_V);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            rgb       <= rgb_t'(FILL_COLOR);
            rgb_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state     <= state_next;
            pix_cnt   <= frame_start ? '0 : pix_cnt_upd;
            rgb       <= consume ? rgb_t'(pix_data) : rgb_t'(FILL_COLOR);
            rgb_valid <= in_frame;
        end
    end

    // Sticky status: an event in the same cycle as status_clr survives the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow   <= 1'b0;
            uflow_count <= '0;
            frame_error <= 1'b0;
        end else begin
            underflow   <= uflow_pix | (underflow & ~status_clr);
            frame_error <= frame_bad | (frame_error & ~status_clr);
            if (status_clr) begin
                uflow_count <= UFLOW_W'(uflow_pix);
            end else if (uflow_pix && (uflow_count != '1)) begin
                uflow_count <= uflow_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Randomised bench for pixel_stream_unpacker against a byte-queue reference model.
module tb_pixel_stream_unpacker;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          N    = H * V;
    localparam int          UW   = 4;
    localparam int          UMAX = (1 << UW) - 1;
    localparam logic [23:0] FILL = 24'hFF00FF;

    logic          clock;
    logic          reset_n;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic          frame_start;
    logic          in_frame;
    logic [23:0]   rgb;
    logic          rgb_valid;
    logic          status_clr;
    logic          underflow;
    logic [UW-1:0] uflow_count;
    logic          frame_error;

    pixel_stream_unpacker #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FILL_COLOR (FILL),
        .UFLOW_W    (UW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .frame_start (frame_start),
        .in_frame    (in_frame),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid),
        .status_clr  (status_clr),
        .underflow   (underflow),
        .uflow_count (uflow_count),
        .frame_error (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes held, upstream words waiting, phase 0/1/2 = idle/priming/running.
    logic [7:0]  q[$];
    logic [31:0] pending[$];
    int          m_phase;
    logic [23:0] m_rgb;
    logic        m_rgb_valid;
    logic        m_uf;
    int          m_ucount;
    int          m_cnt;
    logic        m_ferr;
    bit          auto_feed;

    task automatic model_reset();
        q.delete();
        pending.delete();
        m_phase     = 0;
        m_rgb       = FILL;
        m_rgb_valid = 1'b0;
        m_uf        = 1'b0;
        m_ucount    = 0;
        m_cnt       = 0;
        m_ferr      = 1'b0;
    endtask

    task automatic cycle(input bit want, input bit inf, input bit fs, input bit clr);
        logic        rdy, take, pix_ok, uf, bad;
        int          sz;
        logic [31:0] w;
        @(negedge clock);
        if (auto_feed && pending.size() == 0) pending.push_back($urandom());
        s_valid     = want && (pending.size() > 0);
        s_data      = (pending.size() > 0) ? pending[0] : 32'h0;
        in_frame    = inf;
        frame_start = fs;
        status_clr  = clr;
        sz   = q.size();
        rdy  = (m_phase != 0) && (sz <= 4);
        #1 check("s_ready", s_ready, rdy);
        take   = s_valid && rdy;
        pix_ok = (m_phase == 2) && inf && (sz >= 3);
        uf     = inf && ((m_phase == 1) || ((m_phase == 2) && (sz < 3)));
        m_rgb  = FILL;
        if (pix_ok) begin
            m_rgb = {q[2], q[1], q[0]};
            repeat (3) void'(q.pop_front());
        end
        if (take) begin
            w = pending.pop_front();
            for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
        end
        m_rgb_valid = inf;
        m_uf        = clr ? uf : (m_uf | uf);
        m_ucount    = clr ? int'(uf) : ((uf && m_ucount < UMAX) ? m_ucount + 1 : m_ucount);
        if (m_phase == 2 && inf) m_cnt++;
        bad = fs && (m_phase == 2) && (m_cnt != N);
        if (fs) m_cnt = 0;
        m_ferr = clr ? bad : (m_ferr | bad);
        if (m_phase == 0 && fs) m_phase = 1;
        else if (m_phase == 1 && sz >= 6 && !fs) m_phase = 2;
        @(posedge clock);
        #1;
        check("rgb", rgb, m_rgb);
        check("rgb_valid", rgb_valid, m_rgb_valid);
        check("underflow", underflow, m_uf);
        check("uflow_count", uflow_count, m_ucount);
        check("frame_error", frame_error, m_ferr);
        check("byte_cnt", dut.u_acc.byte_cnt, q.size());
    endtask

    task automatic frame(input bit drop, input bit fs_last);
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                cycle(1, !(drop && v == 1 && h == 3), fs_last && (v == V-1) && (h == H-1), 0);
            end
            if (!(fs_last && v == V-1)) repeat (2) cycle(1, 0, 0, 0);
        end
        if (!fs_last) cycle(1, 0, 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, rgb, FILL);
        check({tag, "_rgb_valid"}, rgb_valid, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_uflow_count"}, uflow_count, 0);
        check({tag, "_frame_error"}, frame_error, 0);
        check({tag, "_byte_cnt"}, dut.u_acc.byte_cnt, 0);
    endtask

    logic [23:0] t1_exp [4];

    initial begin
        t1_exp[0] = 24'h332211;
        t1_exp[1] = 24'h665544;
        t1_exp[2] = 24'h998877;
        t1_exp[3] = 24'hCCBBAA;
        auto_feed   = 0;
        s_valid     = 0;
        s_data      = '0;
        frame_start = 0;
        in_frame    = 0;
        status_clr  = 0;
        reset_n     = 1;
        #1 reset_n  = 0;
        #2 check_reset_outputs("reset");
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1;

        // Directed unpack of three known words.
        cycle(0, 0, 1, 0);
        pending.push_back(32'h44332211);
        pending.push_back(32'h88776655);
        pending.push_back(32'hCCBBAA99);
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0); check("t1_pix0", rgb, t1_exp[0]);
        cycle(1, 1, 0, 0); check("t1_pix1", rgb, t1_exp[1]);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0); check("t1_pix2", rgb, t1_exp[2]);
        cycle(1, 1, 0, 0); check("t1_pix3", rgb, t1_exp[3]);

        // Backpressure with in_frame low: two words fit, then ready stays low.
        repeat (3) pending.push_back($urandom());
        repeat (5) cycle(1, 0, 0, 0);
        check("t2_ready_low", s_ready, 0);

        // Starve the stream until the underflow counter saturates, then clear.
        repeat (20) cycle(0, 1, 0, 0);
        check("t3_uflow_sat", uflow_count, UMAX);
        check("t3_underflow", underflow, 1);
        check("t3_fill", rgb, FILL);
        cycle(0, 1, 0, 1);
        check("t3_clr_event_wins", uflow_count, 1);
        cycle(0, 0, 0, 1);
        check("t3_clr_underflow", underflow, 0);
        check("t3_clr_count", uflow_count, 0);

        // Frame-size checking with continuous data.
        auto_feed = 1;
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 1);
        frame(0, 0);
        check("t4_good_frame", frame_error, 0);
        frame(1, 0);
        check("t4_short_frame", frame_error, 1);
        cycle(1, 0, 0, 1);
        frame(0, 1);
        check("t4_fs_on_last_pixel", frame_error, 0);

        // Random traffic with simultaneous accept and consume.
        for (int i = 0; i < 1000; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset in the middle of a line.
        repeat (3) cycle(1, 1, 0, 0);
        @(posedge clock);
        #3 reset_n = 0;
        #1 check_reset_outputs("midline_reset");
        model_reset();
        @(negedge clock);
        reset_n = 1;
        cycle(1, 0, 1, 0);
        repeat (12) cycle(1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
